// File: rtl/program_loader.sv
// ============================================================================
// program_loader
// ----------------------------------------------------------------------------
// Purpose:
//   Receives a program image over a valid/ready word stream and writes it into
//   separate data and instruction BRAMs. It holds the core PC stalled until
//   loading completes. The image has this layout:
//     word 0 : ND  (data word count, bits [15:0])
//     word 1 : NI  (instruction word count, bits [15:0])
//     ND data words, then NI instruction words
//     [one checksum word when LOADER_CHECKSUM_EN is defined]
//   Bad header counts (NI=0, ND>MAX_WORDS or NI>MAX_WORDS) abort to ERR.
//   A start pulse in RUN or ERR begins a new session.
//
// Configuration macro:
//   LOADER_CHECKSUM_EN - adds the CHK state. In CHK the loader accepts one
//                        extra word that must equal the XOR of all payload
//                        words; a match leads to RUN, a mismatch to ERR.
//
// Ports:
//   clk              in   clock, rising-edge
//   rst              in   asynchronous active-low reset
//   start            in   one-cycle pulse, begins a load session
//   s_valid          in   stream word offered
//   s_data[31:0]     in   stream word
//   s_ready          out  loader accepts the stream word this cycle
//   i_w_addr[9:0]    out  instruction BRAM byte write address
//   i_w_dat[31:0]    out  instruction BRAM write data
//   i_w_enb          out  instruction BRAM write enable
//   d_w_addr[9:0]    out  data BRAM byte write address
//   d_w_dat[31:0]    out  data BRAM write data
//   d_w_enb          out  data BRAM write enable
//   d_bram_init_done out  data BRAM ownership handed to the core
//   pc_stall         out  hold the core PC
//   done             out  load complete, core running
//   error            out  session aborted
// ============================================================================
module program_loader #(
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic [9:0]  i_w_addr,
    output logic [31:0] i_w_dat,
    output logic        i_w_enb,
    output logic [9:0]  d_w_addr,
    output logic [31:0] d_w_dat,
    output logic        d_w_enb,
    output logic        d_bram_init_done,
    output logic        pc_stall,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] HDR_D  = 3'd1;
    localparam logic [2:0] HDR_I  = 3'd2;
    localparam logic [2:0] LOAD_D = 3'd3;
    localparam logic [2:0] LOAD_I = 3'd4;
    localparam logic [2:0] RUN    = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] CHK    = 3'd7;
`endif

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    logic [2:0]  r_state;
    logic [15:0] r_nd;
    logic [15:0] r_ni;
    logic [15:0] r_cnt;
    logic        r_s_ready;
    logic [9:0]  r_i_w_addr;
    logic [31:0] r_i_w_dat;
    logic        r_i_w_enb;
    logic [9:0]  r_d_w_addr;
    logic [31:0] r_d_w_dat;
    logic        r_d_w_enb;
    logic        r_init_done;
    logic        r_pc_stall;
    logic        r_done;
    logic        r_error;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_xor;
`endif

    logic [2:0]  w_next;
    logic        w_acc;
    logic        w_hdr_bad;
    logic        w_last_d;
    logic        w_last_i;
    logic [9:0]  w_addr;
    logic        w_ready_next;
    logic        w_init_next;

    assign w_acc     = s_valid && r_s_ready;
    assign w_last_d  = (r_cnt == r_nd - 16'd1);
    assign w_last_i  = (r_cnt == r_ni - 16'd1);
    assign w_addr    = 10'(r_cnt << 2);
    // NI comes straight from the stream; ND was latched from word 0.
    assign w_hdr_bad = (s_data[15:0] == 16'd0) ||
                       ({1'b0, r_nd} > MAX_W) ||
                       ({1'b0, s_data[15:0]} > MAX_W);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (start) w_next = HDR_D;
            HDR_D:  if (w_acc) w_next = HDR_I;
            HDR_I: begin
                if (w_acc) begin
                    if (w_hdr_bad)          w_next = ERR;
                    else if (r_nd == 16'd0) w_next = LOAD_I;
                    else                    w_next = LOAD_D;
                end
            end
            LOAD_D: if (w_acc && w_last_d) w_next = LOAD_I;
`ifdef LOADER_CHECKSUM_EN
            LOAD_I: if (w_acc && w_last_i) w_next = CHK;
            CHK:    if (w_acc) w_next = (s_data == r_xor) ? RUN : ERR;
`else
            LOAD_I: if (w_acc && w_last_i) w_next = RUN;
`endif
            RUN:    if (start) w_next = HDR_D;
            ERR:    if (start) w_next = HDR_D;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_ready_next = (w_next == HDR_D) || (w_next == HDR_I) ||
                       (w_next == LOAD_D) || (w_next == LOAD_I);
`ifdef LOADER_CHECKSUM_EN
        w_ready_next = w_ready_next || (w_next == CHK);
`endif
    end

    // Ownership handoff: becomes 1 one cycle into LOAD_I (i.e. the cycle after
    // the last data write pulse, or after LOAD_I entry when ND=0) and stays 1
    // until the session leaves the post-data states.
    always_comb begin
        w_init_next = 1'b0;
        if ((w_next == LOAD_I) || (w_next == RUN)
`ifdef LOADER_CHECKSUM_EN
            || (w_next == CHK)
`endif
           ) begin
            w_init_next = r_init_done || (r_state == LOAD_I);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_nd        <= '0;
            r_ni        <= '0;
            r_cnt       <= '0;
            r_s_ready   <= 1'b0;
            r_i_w_addr  <= '0;
            r_i_w_dat   <= '0;
            r_i_w_enb   <= 1'b0;
            r_d_w_addr  <= '0;
            r_d_w_dat   <= '0;
            r_d_w_enb   <= 1'b0;
            r_init_done <= 1'b0;
            r_pc_stall  <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_acc && (r_state == HDR_D)) r_nd <= s_data[15:0];
            if (w_acc && (r_state == HDR_I)) r_ni <= s_data[15:0];

            // Counter restarts on every state change, so each LOAD state starts at 0.
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_acc && ((r_state == LOAD_D) || (r_state == LOAD_I))) begin
                r_cnt <= r_cnt + 16'd1;
            end

            r_d_w_enb <= w_acc && (r_state == LOAD_D);
            if (w_acc && (r_state == LOAD_D)) begin
                r_d_w_addr <= w_addr;
                r_d_w_dat  <= s_data;
            end

            r_i_w_enb <= w_acc && (r_state == LOAD_I);
            if (w_acc && (r_state == LOAD_I)) begin
                r_i_w_addr <= w_addr;
                r_i_w_dat  <= s_data;
            end

            r_s_ready   <= w_ready_next;
            r_init_done <= w_init_next;
            r_pc_stall  <= (w_next != RUN);
            r_done      <= (w_next == RUN);
            r_error     <= (w_next == ERR);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of the payload words only; cleared while the header is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xor <= '0;
        end else if (r_state == HDR_I) begin
            r_xor <= '0;
        end else if (w_acc && ((r_state == LOAD_D) || (r_state == LOAD_I))) begin
            r_xor <= r_xor ^ s_data;
        end
    end
`endif

    assign s_ready          = r_s_ready;
    assign i_w_addr         = r_i_w_addr;
    assign i_w_dat          = r_i_w_dat;
    assign i_w_enb          = r_i_w_enb;
    assign d_w_addr         = r_d_w_addr;
    assign d_w_dat          = r_d_w_dat;
    assign d_w_enb          = r_d_w_enb;
    assign d_bram_init_done = r_init_done;
    assign pc_stall         = r_pc_stall;
    assign done             = r_done;
    assign error            = r_error;

endmodule
